// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port used by the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 4
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses HEADER/N/data/CHK frames, writes big-endian words into
// instruction memory and releases the core once a frame checks out.
module imem_loader #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  imem_loader_if.slave    bus,
  output logic            core_reset,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic [7:0]      chk_q;
  logic            accept;
  logic [ADDR_W:0] wc_next;

  assign accept  = bus.byte_valid && bus.byte_ready;
  assign wc_next = word_count + (ADDR_W+1)'(1);

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments appear in this block; blocking ones would race with readers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      bus.byte_ready <= 1'b0;
      bus.im_we      <= 1'b0;
      bus.im_addr    <= '0;
      bus.im_wdata   <= '0;
      core_reset     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      word_count     <= '0;
      len_q          <= '0;
      byte_idx       <= '0;
      asm_q          <= '0;
      chk_q          <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.byte_ready <= 1'b1;
          if (accept && bus.byte_data == HEADER) begin
            state      <= S_LEN;
            busy       <= 1'b1;
            err        <= 1'b0;
            word_count <= '0;
            chk_q      <= '0;
            byte_idx   <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (bus.byte_data != 8'd0 && bus.byte_data <= 8'(DEPTH)) begin
              len_q <= bus.byte_data[ADDR_W:0];
              state <= S_DATA;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_q    <= {asm_q[15:0], bus.byte_data};
            chk_q    <= chk_q ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte completes the word; the write pulse and count bump
            // land together on the following cycle.
            if (byte_idx == 2'd3) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= word_count[ADDR_W-1:0];
              bus.im_wdata <= {asm_q, bus.byte_data};
              word_count   <= wc_next;
              if (wc_next == len_q) state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (bus.byte_data == chk_q) begin
              state          <= S_DONE;
              done           <= 1'b1;
              core_reset     <= 1'b0;
              bus.byte_ready <= 1'b0;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          bus.byte_ready <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frame stimulus for imem_loader, checked against a
// frame-level parser model of the loader protocol.
module tb_imem_loader;
  localparam int         DEPTH  = 16;
  localparam int         ADDR_W = 4;
  localparam logic [7:0] HEADER = 8'hA5;

  typedef logic [7:0] byte_t;
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            core_reset, busy, done, err;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADER(HEADER)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  wr_t   act_log[$];
  wr_t   exp_log[$];
  byte_t hist[$];
  logic  exp_err, exp_done;
  int    exp_wc;

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) act_log.push_back('{int'(bus.im_addr), bus.im_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Parses the accepted byte history frame by frame from the protocol rules.
  task automatic model(input byte_t s[$]);
    int p, n, w;
    byte_t x;
    logic [31:0] word;
    exp_log.delete();
    exp_err = 1'b0; exp_done = 1'b0; exp_wc = 0; p = 0;
    while (p < s.size() && !exp_done) begin
      if (s[p] != HEADER) begin
        p++;
        continue;
      end
      if (p + 1 >= s.size()) break;
      n = int'(s[p+1]);
      p += 2;
      exp_err = 1'b0; exp_wc = 0;
      if (n < 1 || n > DEPTH) begin
        exp_err = 1'b1;
        continue;
      end
      x = 8'h00;
      for (w = 0; w < n && p + 4 <= s.size(); w++) begin
        word = {s[p], s[p+1], s[p+2], s[p+3]};
        x ^= word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
        exp_log.push_back('{w, word});
        exp_wc++;
        p += 4;
      end
      if (w < n || p >= s.size()) break;
      if (s[p] == x) exp_done = 1'b1;
      else           exp_err  = 1'b1;
      p++;
    end
  endtask

  task automatic send_byte(input byte_t b, input bit rnd);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 100) begin
      bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = b;
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.byte_valid = 1'b0;
    check("byte_accepted", 64'(acc), 64'd1);
    if (acc) hist.push_back(b);
  endtask

  task automatic send(input byte_t f[$], input bit rnd);
    foreach (f[i]) send_byte(f[i], rnd);
  endtask

  task automatic settle();
    bus.byte_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame(input string tag);
    int m;
    settle();
    model(hist);
    check({tag, "_nwrites"}, 64'(act_log.size()), 64'(exp_log.size()));
    m = (act_log.size() < exp_log.size()) ? act_log.size() : exp_log.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_waddr"}, 64'(act_log[i].addr), 64'(exp_log[i].addr));
      check({tag, "_wdata"}, 64'(act_log[i].data), 64'(exp_log[i].data));
    end
    check({tag, "_err"},        64'(err),        64'(exp_err));
    check({tag, "_done"},       64'(done),       64'(exp_done));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(!exp_done));
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'(exp_wc));
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'(!exp_done));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 64'(core_reset),      64'd1);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready),  64'd0);
    check({tag, "_im_we"},      64'(bus.im_we),       64'd0);
    check({tag, "_im_addr"},    64'(bus.im_addr),     64'd0);
    check({tag, "_im_wdata"},   64'(bus.im_wdata),    64'd0);
    check({tag, "_busy"},       64'(busy),            64'd0);
    check({tag, "_done"},       64'(done),            64'd0);
    check({tag, "_err"},        64'(err),             64'd0);
    check({tag, "_word_count"}, 64'(word_count),      64'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    act_log.delete();
    hist.delete();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  byte_t frame1[$]  = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h02, 8'h20, 8'h0A, 8'h00, 8'h01, 8'h01};
  byte_t frame1b[$] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h02, 8'h20, 8'h0A, 8'h00, 8'h01, 8'h00};

  initial begin
    byte_t f[$];
    byte_t x, b;
    int n;

    // Reset state, then the first frame with byte_valid held high.
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    check_reset_vals("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_after_release", 64'(bus.byte_ready), 64'd1);
    for (int i = 0; i < frame1.size() - 1; i++) send_byte(frame1[i], 1'b0);
    check("t1_done_before_chk", 64'(done), 64'd0);
    send_byte(frame1[frame1.size()-1], 1'b0);
    check("t1_done_next_cycle", 64'(done), 64'd1);
    check("t1_core_release", 64'(core_reset), 64'd0);
    check_frame("t1");

    // Bad checksum, then a good frame recovers.
    apply_reset();
    send(frame1b, 1'b0);
    check_frame("t2_bad");
    send(frame1, 1'b0);
    check_frame("t2_good");

    // Leading garbage is discarded.
    apply_reset();
    f = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'hAC, 8'h09, 8'h00, 8'h04, 8'hA1};
    send(f, 1'b0);
    check_frame("t3");

    // Length bounds.
    apply_reset();
    f = '{8'hA5, 8'h00};
    send(f, 1'b0);
    check_frame("t4_len0");
    f = '{8'hA5, 8'h11};
    send(f, 1'b0);
    check_frame("t4_len17");
    f = '{8'hA5, 8'h10};
    for (int i = 0; i < 4 * DEPTH; i++) f.push_back(byte_t'(i));
    f.push_back(8'h00);
    send(f, 1'b0);
    check_frame("t4_len16");

    // Reset in the middle of a word, then a fresh one-word frame.
    apply_reset();
    f = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send(f, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("t5_midrst");
    reset = 1'b1;
    hist.delete();
    @(posedge clk); #1;
    f = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send(f, 1'b0);
    check_frame("t5");

    // Random valid gaps on the first frame, then poke the terminal state.
    apply_reset();
    send(frame1, 1'b1);
    check_frame("t6");
    for (int i = 0; i < 6; i++) begin
      bus.byte_valid = 1'($urandom_range(0, 1));
      bus.byte_data  = HEADER;
      @(posedge clk); #1;
      check("t6_done_ready_low", 64'(bus.byte_ready), 64'd0);
    end
    bus.byte_valid = 1'b0;
    check_frame("t6_after_pokes");

    // Randomized frames: corrupted checksum followed by a good frame.
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      for (int pass = 0; pass < 2; pass++) begin
        f.delete();
        repeat ($urandom_range(0, 3)) begin
          b = byte_t'($urandom_range(0, 255));
          f.push_back((b == HEADER) ? 8'h00 : b);
        end
        n = $urandom_range(1, DEPTH);
        f.push_back(HEADER);
        f.push_back(byte_t'(n));
        x = 8'h00;
        repeat (4 * n) begin
          b = byte_t'($urandom_range(0, 255));
          f.push_back(b);
          x ^= b;
        end
        f.push_back((pass == 0) ? (x ^ byte_t'($urandom_range(1, 255))) : x);
        send(f, 1'b1);
        check_frame((pass == 0) ? "rand_bad" : "rand_good");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
